// File: rtl/random_grid_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | random_grid_gen                                                        |
// | Free-running LFSR food-cell picker: cell-aligned (x,y) inside the grid |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module random_grid_gen #(
  parameter int unsigned CELL_SIZE = 10,
  parameter int unsigned H_CELLS   = 64,
  parameter int unsigned V_CELLS   = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [8:0] y
);

  localparam int unsigned CXB = (H_CELLS > 1) ? $clog2(H_CELLS) : 1;
  localparam int unsigned CYB = (V_CELLS > 1) ? $clog2(V_CELLS) : 1;

  localparam logic [15:0] C_SEED_X = 16'hACE1;
  localparam logic [16:0] C_SEED_Y = 17'h15A5A;

  logic [15:0]    r_lfsr_x;
  logic [16:0]    r_lfsr_y;
  logic [15:0]    w_lfsr_x_nxt;
  logic [16:0]    w_lfsr_y_nxt;
  logic           w_fb_x;
  logic           w_fb_y;
  logic [CXB-1:0] w_cand_col;
  logic [CYB-1:0] w_cand_row;
  logic           w_col_ok;
  logic           w_row_ok;
  logic [9:0]     w_x_cand;
  logic [8:0]     w_y_cand;

  assign w_fb_x = r_lfsr_x[15] ^ r_lfsr_x[13] ^ r_lfsr_x[12] ^ r_lfsr_x[10];
  assign w_fb_y = r_lfsr_y[16] ^ r_lfsr_y[13];

  // An all-zero register would never leave that state, so reload the seed instead.
  assign w_lfsr_x_nxt = (r_lfsr_x == '0) ? C_SEED_X : {r_lfsr_x[14:0], w_fb_x};
  assign w_lfsr_y_nxt = (r_lfsr_y == '0) ? C_SEED_Y : {r_lfsr_y[15:0], w_fb_y};

  assign w_cand_col = r_lfsr_x[CXB-1:0];
  assign w_cand_row = r_lfsr_y[CYB-1:0];

  // Out-of-range candidates are rejected rather than folded, keeping the distribution flat.
  assign w_col_ok = (32'(w_cand_col) < H_CELLS);
  assign w_row_ok = (32'(w_cand_row) < V_CELLS);

  assign w_x_cand = 10'(32'(w_cand_col) * CELL_SIZE);
  assign w_y_cand = 9'(32'(w_cand_row) * CELL_SIZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr_x <= C_SEED_X;
      r_lfsr_y <= C_SEED_Y;
    end else begin
      r_lfsr_x <= w_lfsr_x_nxt;
      r_lfsr_y <= w_lfsr_y_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      if (w_col_ok) begin
        x <= w_x_cand;
      end
      if (w_row_ok) begin
        y <= w_y_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_random_grid_gen.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for random_grid_gen against an arithmetic LFSR reference model.
module tb_random_grid_gen;

  localparam int unsigned CELL = 10;
  localparam int unsigned HC   = 64;
  localparam int unsigned VC   = 48;
  localparam int unsigned XMOD = 1 << $clog2(HC);
  localparam int unsigned YMOD = 1 << $clog2(VC);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x;
  logic [8:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_lx;
  int unsigned m_ly;
  logic [9:0]  e_x;
  logic [8:0]  e_y;
  logic [9:0]  g_x [20];
  logic [8:0]  g_y [20];
  bit          seen_x [HC];
  bit          seen_y [VC];

  random_grid_gen #(.CELL_SIZE(CELL), .H_CELLS(HC), .V_CELLS(VC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .y    (y)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_lx = 32'hACE1;
    m_ly = 32'h15A5A;
    e_x  = '0;
    e_y  = '0;
  endfunction

  function automatic void model_step();
    int unsigned col;
    int unsigned row;
    int unsigned fb;
    col = m_lx % XMOD;
    row = m_ly % YMOD;
    if (col < HC) e_x = 10'(col * CELL);
    if (row < VC) e_y = 9'(row * CELL);
    if (m_lx == 0) m_lx = 32'hACE1;
    else begin
      fb   = ((m_lx >> 15) ^ (m_lx >> 13) ^ (m_lx >> 12) ^ (m_lx >> 10)) & 1;
      m_lx = ((m_lx * 2) % 65536) + fb;
    end
    if (m_ly == 0) m_ly = 32'h15A5A;
    else begin
      fb   = ((m_ly >> 16) ^ (m_ly >> 13)) & 1;
      m_ly = ((m_ly * 2) % 131072) + fb;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (x !== 10'd0 || y !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: x=%0d y=%0d, required x=0 y=0", i, x, y);
      end
    end
  endtask

  task automatic test_first_edge();
    release_reset();
    tick();
    n_checks++;
    if (x !== 10'd330) begin
      n_fail++;
      $display("FAIL first_edge_x: got %0d, required 330", x);
    end
    n_checks++;
    if (y !== 9'd260) begin
      n_fail++;
      $display("FAIL first_edge_y: got %0d, required 260", y);
    end
  endtask

  task automatic test_model_run(input int ncycles, input bit check_cov);
    int miss_x;
    int miss_y;
    for (int i = 0; i < HC; i++) seen_x[i] = 1'b0;
    for (int i = 0; i < VC; i++) seen_y[i] = 1'b0;
    for (int i = 0; i < ncycles; i++) begin
      tick();
      n_checks++;
      if (x !== e_x || y !== e_y) begin
        n_fail++;
        $display("FAIL model_match cycle %0d: x=%0d y=%0d, required x=%0d y=%0d",
                 i, x, y, e_x, e_y);
      end
      n_checks++;
      if ((x % CELL) != 0 || x > 10'(CELL * (HC - 1)) || (y % CELL) != 0 ||
          y > 9'(CELL * (VC - 1))) begin
        n_fail++;
        $display("FAIL invariant cycle %0d: x=%0d y=%0d, required multiples of %0d, x<=%0d y<=%0d",
                 i, x, y, CELL, CELL * (HC - 1), CELL * (VC - 1));
      end else begin
        seen_x[x / CELL] = 1'b1;
        seen_y[y / CELL] = 1'b1;
      end
    end
    if (check_cov) begin
      miss_x = 0;
      miss_y = 0;
      for (int i = 0; i < HC; i++) if (!seen_x[i]) miss_x++;
      for (int i = 0; i < VC; i++) if (!seen_y[i]) miss_y++;
      n_checks++;
      if (miss_x != 0 || miss_y != 0) begin
        n_fail++;
        $display("FAIL coverage: missing x=%0d y=%0d values, required 0 missing", miss_x, miss_y);
      end
    end
  endtask

  task automatic test_mid_reset(input int hold_cycles);
    tick();
    #($urandom_range(1, 7));
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (x !== 10'd0 || y !== 9'd0) begin
      n_fail++;
      $display("FAIL async_reset: x=%0d y=%0d, required 0 0 before any edge", x, y);
    end
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (x !== 10'd0 || y !== 9'd0) begin
        n_fail++;
        $display("FAIL mid_reset_hold cycle %0d: x=%0d y=%0d, required 0 0", i, x, y);
      end
    end
    release_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (x !== g_x[i] || y !== g_y[i]) begin
        n_fail++;
        $display("FAIL replay step %0d: x=%0d y=%0d, required x=%0d y=%0d",
                 i, x, y, g_x[i], g_y[i]);
      end
    end
  endtask

  task automatic test_lockup();
    tick();
    force dut.r_lfsr_x = 16'h0000;
    #1;
    release dut.r_lfsr_x;
    m_lx = 0;
    tick();
    n_checks++;
    if (x !== e_x || x !== 10'd0) begin
      n_fail++;
      $display("FAIL lockup_x: got %0d, required 0", x);
    end
    n_checks++;
    if (dut.r_lfsr_x !== 16'hACE1) begin
      n_fail++;
      $display("FAIL lockup_reload: lfsr_x=%h, required ace1", dut.r_lfsr_x);
    end
    test_model_run(300, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      test_model_run(int'($urandom_range(50, 500)), 1'b0);
      test_mid_reset(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 20; i++) begin
      model_step();
      g_x[i] = e_x;
      g_y[i] = e_y;
    end
    model_reset();
    #2;
    test_reset();
    test_first_edge();
    test_model_run(20000, 1'b1);
    test_mid_reset(3);
    test_lockup();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
